// File: rtl/arc4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : arc4_pkg                                                         |
// | Purpose : Shared types and helpers for the ARC4 state-array scheduler:     |
// |           FSM state encoding, run-length helper and key byte selection.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package arc4_pkg;

    // Encodings are fixed so they can be mirrored as plain 3-bit constants.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RD_I = 3'd2,
        RD_J = 3'd3,
        WR_J = 3'd4,
        WR_I = 3'd5,
        DONE = 3'd6
    } arc4_sched_state_t;

    // Widest key the byte selector handles (32 bytes).
    localparam int c_KEY_MAX_BITS = 256;

    // Clock cycles from the accepting edge up to and including the DONE cycle.
    function automatic int cycles_per_run(input int addr_w, input logic skip);
        return (skip ? 4 : 5) * (1 << addr_w) + 1;
    endfunction

    // Key bytes are numbered MSB first, so the key is left-justified in a
    // 256-bit word and byte idx is taken counting down from the top.
    function automatic logic [7:0] key_byte(input logic [c_KEY_MAX_BITS-1:0] key_left,
                                            input int idx);
        return key_left[c_KEY_MAX_BITS-1-8*idx -: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/arc4_key_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : arc4_key_sel                                                     |
// | Purpose : Holds the key captured at run start and walks the key-byte index |
// |           (wrapping at KEY_BYTES-1), presenting the current key byte.      |
// | Ports   : clk, rst      - clock, synchronous active-high reset             |
// |           i_load        - capture i_key and clear the byte index           |
// |           i_key         - key, byte 0 in the most significant byte         |
// |           i_advance     - step to the next key byte                        |
// |           o_key_byte    - key byte selected by the current index           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module arc4_key_sel
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [8*KEY_BYTES-1:0] i_key,
    input  logic                   i_advance,
    output logic [7:0]             o_key_byte
);

    // A one-byte key still gets a 1-bit index that simply never moves.
    localparam int c_KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [c_KIDX_W-1:0] c_KIDX_LAST = c_KIDX_W'(KEY_BYTES - 1);

    logic [8*KEY_BYTES-1:0]    r_key;
    logic [c_KIDX_W-1:0]       r_kidx;
    logic [c_KEY_MAX_BITS-1:0] w_key_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key  <= '0;
            r_kidx <= '0;
        end else if (i_load) begin
            r_key  <= i_key;
            r_kidx <= '0;
        end else if (i_advance) begin
            if (r_kidx == c_KIDX_LAST) begin
                r_kidx <= '0;
            end else begin
                r_kidx <= r_kidx + 1'b1;
            end
        end
    end

    assign w_key_left = c_KEY_MAX_BITS'(r_key) << (c_KEY_MAX_BITS - 8*KEY_BYTES);
    assign o_key_byte = key_byte(w_key_left, int'(r_kidx));

endmodule
`default_nettype wire

// File: rtl/arc4_sched_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : arc4_sched_engine                                                |
// | Purpose : ARC4 state-array engine. Fills S[i]=i, then runs the key         |
// |           scheduling swap loop over an external single-port synchronous   |
// |           RAM (registered address, one-cycle read latency). Owns the RAM  |
// |           port while busy.                                                 |
// | Ports   : clk, rst      - clock, synchronous active-high reset             |
// |           en            - start request, honoured only while rdy=1         |
// |           skip_init     - with en: skip the fill, run KSA on existing S    |
// |           key           - key, byte 0 = MSB byte, captured at start        |
// |           rdy           - idle, can accept en                              |
// |           done          - one-cycle pulse at end of run                    |
// |           addr/wrdata/wren/rddata - RAM port                               |
// |           cycle_count   - (ARC4_SCHED_CYCLE_COUNT_EN only) busy cycles     |
// | Options : `define ARC4_SCHED_CYCLE_COUNT_EN adds the cycle_count output.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module arc4_sched_engine
    import arc4_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   skip_init,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   rdy,
    output logic                   done,
    output logic [ADDR_W-1:0]      addr,
    output logic [7:0]             wrdata,
    output logic                   wren,
    input  logic [7:0]             rddata
`ifdef ARC4_SCHED_CYCLE_COUNT_EN
    ,
    output logic [15:0]            cycle_count
`endif
);

    localparam logic [2:0] c_ST_IDLE = IDLE;
    localparam logic [2:0] c_ST_INIT = INIT;
    localparam logic [2:0] c_ST_RD_I = RD_I;
    localparam logic [2:0] c_ST_RD_J = RD_J;
    localparam logic [2:0] c_ST_WR_J = WR_J;
    localparam logic [2:0] c_ST_WR_I = WR_I;
    localparam logic [2:0] c_ST_DONE = DONE;

    localparam logic [ADDR_W-1:0] c_I_LAST = {ADDR_W{1'b1}};

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_j;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;

    logic              w_accept;
    logic              w_key_adv;
    logic [7:0]        w_key_byte;
    logic [7:0]        w_j_sum;
    logic [ADDR_W-1:0] w_j_next;

    assign w_accept  = (r_state == c_ST_IDLE) && en;
    assign w_key_adv = (r_state == c_ST_WR_I);

    arc4_key_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_key      (key),
        .i_advance  (w_key_adv),
        .o_key_byte (w_key_byte)
    );

    // In RD_J the RAM returns S[i]; the new j is formed at 8 bits and the
    // low ADDR_W bits give the mod-N wrap.
    assign w_j_sum  = 8'(r_j) + rddata + w_key_byte;
    assign w_j_next = w_j_sum[ADDR_W-1:0];

    generate
        if (ADDR_W < 8) begin : g_sum_trunc
            logic w_unused_sum_hi;
            assign w_unused_sum_hi = ^w_j_sum[7:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (en) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_state <= skip_init ? c_ST_RD_I : c_ST_INIT;
                    end
                end
                c_ST_INIT: begin
                    // i wraps back to 0 on the last fill, ready for the KSA loop.
                    r_i <= r_i + 1'b1;
                    if (r_i == c_I_LAST) begin
                        r_state <= c_ST_RD_I;
                    end
                end
                c_ST_RD_I: begin
                    r_state <= c_ST_RD_J;
                end
                c_ST_RD_J: begin
                    r_si    <= rddata;
                    r_j     <= w_j_next;
                    r_state <= c_ST_WR_J;
                end
                c_ST_WR_J: begin
                    // Read of S[j] issued in RD_J lands here, before S[j] is written.
                    r_sj    <= rddata;
                    r_state <= c_ST_WR_I;
                end
                c_ST_WR_I: begin
                    if (r_i == c_I_LAST) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_i     <= r_i + 1'b1;
                        r_state <= c_ST_RD_I;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdy    = 1'b0;
        done   = 1'b0;
        wren   = 1'b0;
        addr   = '0;
        wrdata = '0;
        case (r_state)
            c_ST_IDLE: begin
                rdy = 1'b1;
            end
            c_ST_INIT: begin
                addr   = r_i;
                wrdata = 8'(r_i);
                wren   = 1'b1;
            end
            c_ST_RD_I: begin
                addr = r_i;
            end
            c_ST_RD_J: begin
                addr = w_j_next;
            end
            c_ST_WR_J: begin
                addr   = r_j;
                wrdata = r_si;
                wren   = 1'b1;
            end
            c_ST_WR_I: begin
                // When i==j this rewrites the value WR_J just stored.
                addr   = r_i;
                wrdata = r_sj;
                wren   = 1'b1;
            end
            c_ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef ARC4_SCHED_CYCLE_COUNT_EN
    logic [15:0] r_cycle_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
        end else if (w_accept) begin
            r_cycle_count <= '0;
        end else if ((r_state != c_ST_IDLE) && (r_cycle_count != 16'hFFFF)) begin
            r_cycle_count <= r_cycle_count + 16'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire
